// File: rtl/ddram_ch_arb_pkg.sv
// Shared definitions for the DDRAM channel arbiter.
// Holds the FSM state encoding and the default sizing parameters.
package ddram_arb_pkg;

    localparam int          NREQ_DEF    = 3;
    localparam int          TIMEOUT_DEF = 1023;
    localparam logic [31:0] TMO_DATA    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ddram_ch_arb_if.sv
// Requester-side and channel-side buses of the DDRAM channel arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface ddram_ch_arb_if
    import ddram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) ();

    logic [NREQ-1:0][27:1] rq_addr;
    logic [NREQ-1:0][31:0] rq_din;
    logic [NREQ-1:0]       rq_rnw;
    logic [NREQ-1:0]       rq_req;
    logic [31:0]           rq_dout;
    logic [NREQ-1:0]       rq_ready;
    logic [27:1]           ch_addr;
    logic [31:0]           ch_din;
    logic                  ch_rnw;
    logic                  ch_req;
    logic [31:0]           ch_dout;
    logic                  ch_ready;

    modport master (
        input  rq_addr, rq_din, rq_rnw, rq_req, ch_dout, ch_ready,
        output rq_dout, rq_ready, ch_addr, ch_din, ch_rnw, ch_req
    );

    modport slave (
        output rq_addr, rq_din, rq_rnw, rq_req, ch_dout, ch_ready,
        input  rq_dout, rq_ready, ch_addr, ch_din, ch_rnw, ch_req
    );

endinterface

// File: rtl/ddram_ch_arb_rr_pick.sv
// Combinational round-robin picker: first requester found when searching
// upward from (ptr + 1) mod NREQ.
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      idx,
    output logic            valid
);

    logic [1:0] cand_s;
    logic       hit_s;

    // Walk candidates farthest-first so the nearest hit overwrites the rest.
    always_comb begin
        idx    = 2'd0;
        valid  = 1'b0;
        cand_s = 2'd0;
        hit_s  = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            cand_s = 2'((int'(ptr) + i) % NREQ);
            hit_s  = req[cand_s];
            idx    = hit_s ? cand_s : idx;
            valid  = valid | hit_s;
        end
    end

endmodule

// File: rtl/ddram_ch_arb.sv
// Round-robin arbiter sharing one 32-bit DDRAM channel between NREQ
// requesters, with a bounded wait for channel completion.
module ddram_ch_arb
    import ddram_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           DDRAM_CLK,
    input  logic           DDRAM_RESET_N,
    ddram_ch_arb_if.master bus,
    output logic           err_timeout,
    output logic [1:0]     grant_id
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [1:0]    PTR_RST = 2'(NREQ - 1);

    arb_state_e      state_r, state_nx_s;
    logic [1:0]      ptr_r, ptr_nx_s;
    logic [1:0]      grant_r, grant_nx_s;
    logic [1:0]      pick_idx_s;
    logic            pick_vld_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic [27:1]     ch_addr_r, ch_addr_nx_s;
    logic [31:0]     ch_din_r, ch_din_nx_s;
    logic            ch_rnw_r, ch_rnw_nx_s;
    logic            ch_req_r, ch_req_nx_s;
    logic [31:0]     rq_dout_r, rq_dout_nx_s;
    logic [NREQ-1:0] rq_ready_r, rq_ready_nx_s;
    logic            err_r, err_nx_s;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (bus.rq_req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_vld_s)
    );

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_nx_s    = state_r;
        ptr_nx_s      = ptr_r;
        grant_nx_s    = grant_r;
        cnt_nx_s      = cnt_r;
        ch_addr_nx_s  = ch_addr_r;
        ch_din_nx_s   = ch_din_r;
        ch_rnw_nx_s   = ch_rnw_r;
        ch_req_nx_s   = 1'b0;
        rq_dout_nx_s  = rq_dout_r;
        rq_ready_nx_s = '0;
        err_nx_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_nx_s   = ST_ISSUE;
                    ptr_nx_s     = pick_idx_s;
                    grant_nx_s   = pick_idx_s;
                    ch_addr_nx_s = bus.rq_addr[pick_idx_s];
                    ch_din_nx_s  = bus.rq_din[pick_idx_s];
                    ch_rnw_nx_s  = bus.rq_rnw[pick_idx_s];
                    ch_req_nx_s  = 1'b1;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_WAIT;
                cnt_nx_s   = '0;
            end
            ST_WAIT: begin
                // A completion on the expiry cycle still counts as success.
                if (bus.ch_ready) begin
                    state_nx_s             = ST_DONE;
                    rq_dout_nx_s           = bus.ch_dout;
                    rq_ready_nx_s[grant_r] = 1'b1;
                end else if (cnt_r == CNT_MAX) begin
                    state_nx_s             = ST_DONE;
                    rq_dout_nx_s           = TMO_DATA;
                    rq_ready_nx_s[grant_r] = 1'b1;
                    err_nx_s               = 1'b1;
                end else begin
                    cnt_nx_s               = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_RST;
            grant_r    <= 2'd0;
            cnt_r      <= '0;
            ch_addr_r  <= 27'd0;
            ch_din_r   <= 32'd0;
            ch_rnw_r   <= 1'b0;
            ch_req_r   <= 1'b0;
            rq_dout_r  <= 32'd0;
            rq_ready_r <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            grant_r    <= grant_nx_s;
            cnt_r      <= cnt_nx_s;
            ch_addr_r  <= ch_addr_nx_s;
            ch_din_r   <= ch_din_nx_s;
            ch_rnw_r   <= ch_rnw_nx_s;
            ch_req_r   <= ch_req_nx_s;
            rq_dout_r  <= rq_dout_nx_s;
            rq_ready_r <= rq_ready_nx_s;
            err_r      <= err_nx_s;
        end
    end

    assign bus.ch_addr  = ch_addr_r;
    assign bus.ch_din   = ch_din_r;
    assign bus.ch_rnw   = ch_rnw_r;
    assign bus.ch_req   = ch_req_r;
    assign bus.rq_dout  = rq_dout_r;
    assign bus.rq_ready = rq_ready_r;
    assign err_timeout  = err_r;
    assign grant_id     = grant_r;

endmodule

// File: tb/tb_ddram_ch_arb.sv
// Directed self-checking bench for ddram_ch_arb (NREQ=3, TIMEOUT=15).
module tb_ddram_ch_arb;
    import ddram_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       err_timeout;
    logic [1:0] grant_id;
    int         checks;
    int         failures;
    int         chreq_cnt;
    int         ready_cnt;

    ddram_ch_arb_if #(.NREQ(3)) bus ();

    ddram_ch_arb #(
        .NREQ    (3),
        .TIMEOUT (15)
    ) dut (
        .DDRAM_CLK     (clk),
        .DDRAM_RESET_N (rst_n),
        .bus           (bus),
        .err_timeout   (err_timeout),
        .grant_id      (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
        if (bus.ch_req === 1'b1) chreq_cnt++;
        if (bus.rq_ready !== 3'b000) ready_cnt++;
    endtask

    task automatic clear_inputs();
        bus.rq_addr  = '0;
        bus.rq_din   = '0;
        bus.rq_rnw   = 3'b000;
        bus.rq_req   = 3'b000;
        bus.ch_dout  = 32'd0;
        bus.ch_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chreq_cnt = 0;
        ready_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.ch_req !== 1'b0) begin failures++; $display("FAIL reset_ch_req got=%0h exp=0", bus.ch_req); end
        checks++; if (bus.rq_ready !== 3'b000) begin failures++; $display("FAIL reset_rq_ready got=%0h exp=0", bus.rq_ready); end
        checks++; if (bus.rq_dout !== 32'd0) begin failures++; $display("FAIL reset_rq_dout got=%0h exp=0", bus.rq_dout); end
        checks++; if (bus.ch_addr !== 27'd0) begin failures++; $display("FAIL reset_ch_addr got=%0h exp=0", bus.ch_addr); end
        checks++; if (bus.ch_din !== 32'd0) begin failures++; $display("FAIL reset_ch_din got=%0h exp=0", bus.ch_din); end
        checks++; if (bus.ch_rnw !== 1'b0) begin failures++; $display("FAIL reset_ch_rnw got=%0h exp=0", bus.ch_rnw); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err_timeout); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0h exp=0", grant_id); end
        checks++; if (dut.state_r !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0h exp=%0h", dut.state_r, ST_IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int n;
        chreq_cnt = 0;
        ready_cnt = 0;
        bus.rq_addr[0] = 27'h100;
        bus.rq_rnw[0]  = 1'b1;
        bus.rq_req[0]  = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.ch_req !== 1'b1 && n < 10);
        checks++; if (n != 1) begin failures++; $display("FAIL read_req_latency got=%0d exp=1", n); end
        checks++; if (bus.ch_addr !== 27'h100) begin failures++; $display("FAIL read_ch_addr got=%0h exp=100", bus.ch_addr); end
        checks++; if (bus.ch_rnw !== 1'b1) begin failures++; $display("FAIL read_ch_rnw got=%0h exp=1", bus.ch_rnw); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL read_grant got=%0h exp=0", grant_id); end
        // A completion pulse while still in ISSUE must be ignored.
        bus.ch_ready = 1'b1;
        bus.ch_dout  = 32'h0BAD_0BAD;
        tick();
        bus.ch_ready = 1'b0;
        checks++; if (bus.ch_req !== 1'b0) begin failures++; $display("FAIL read_ch_req_pulse got=%0h exp=0", bus.ch_req); end
        repeat (3) tick();
        checks++; if (bus.rq_ready !== 3'b000) begin failures++; $display("FAIL read_early_ready got=%0h exp=0", bus.rq_ready); end
        bus.ch_ready = 1'b1;
        bus.ch_dout  = 32'hDEAD_BEEF;
        tick();
        bus.ch_ready = 1'b0;
        checks++; if (bus.rq_ready !== 3'b001) begin failures++; $display("FAIL read_rq_ready got=%0h exp=1", bus.rq_ready); end
        checks++; if (bus.rq_dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rq_dout got=%0h exp=deadbeef", bus.rq_dout); end
        bus.rq_req = 3'b000;
        tick();
        checks++; if (bus.rq_ready !== 3'b000) begin failures++; $display("FAIL read_ready_drop got=%0h exp=0", bus.rq_ready); end
        checks++; if (chreq_cnt != 1) begin failures++; $display("FAIL read_ch_req_count got=%0d exp=1", chreq_cnt); end
        checks++; if (ready_cnt != 1) begin failures++; $display("FAIL read_ready_count got=%0d exp=1", ready_cnt); end
    endtask

    task automatic test_fairness();
        int g[12];
        int gt[12];
        int served[3];
        int ng;
        int nr;
        int t;
        bit pend;
        bit multi;
        apply_reset();
        ng = 0; nr = 0; t = 0; pend = 1'b0; multi = 1'b0;
        for (int j = 0; j < 3; j++) served[j] = 0;
        bus.rq_addr[0] = 27'h10; bus.rq_addr[1] = 27'h20; bus.rq_addr[2] = 27'h30;
        bus.rq_rnw = 3'b111;
        bus.rq_req = 3'b111;
        while (nr < 12 && t < 200) begin
            tick();
            t++;
            bus.ch_ready = 1'b0;
            if ($countones(bus.rq_ready) > 1) multi = 1'b1;
            for (int j = 0; j < 3; j++) if (bus.rq_ready[j] === 1'b1) served[j]++;
            if (bus.rq_ready !== 3'b000) begin
                nr++;
                if (nr == 12) bus.rq_req = 3'b000;
            end
            if (pend) begin
                bus.ch_ready = 1'b1;
                bus.ch_dout  = 32'(t);
                pend = 1'b0;
            end
            if (bus.ch_req === 1'b1) begin
                if (ng < 12) begin g[ng] = int'(grant_id); gt[ng] = t; end
                ng++;
                pend = 1'b1;
            end
        end
        checks++; if (nr != 12) begin failures++; $display("FAIL fair_completions got=%0d exp=12", nr); end
        checks++; if (ng != 12) begin failures++; $display("FAIL fair_grants got=%0d exp=12", ng); end
        for (int k = 0; k < 12 && k < ng; k++) begin
            checks++; if (g[k] != k % 3) begin failures++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", k, g[k], k % 3); end
        end
        for (int k = 1; k < 12 && k < ng; k++) begin
            checks++; if (gt[k] - gt[k-1] != 4) begin failures++; $display("FAIL fair_interval[%0d] got=%0d exp=4", k, gt[k] - gt[k-1]); end
        end
        for (int j = 0; j < 3; j++) begin
            checks++; if (served[j] != 4) begin failures++; $display("FAIL fair_served[%0d] got=%0d exp=4", j, served[j]); end
        end
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL fair_onehot got=%0d exp=0", multi); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_err_before got=%0h exp=0", err_timeout); end
        bus.rq_addr[1] = 27'h4444;
        bus.rq_rnw[1]  = 1'b1;
        bus.rq_req     = 3'b010;
        n = 0;
        do begin tick(); n++; end while (bus.ch_req !== 1'b1 && n < 10);
        checks++; if (bus.ch_req !== 1'b1) begin failures++; $display("FAIL tmo_ch_req got=%0h exp=1", bus.ch_req); end
        checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL tmo_grant got=%0h exp=1", grant_id); end
        n = 0;
        do begin tick(); n++; end while (bus.rq_ready === 3'b000 && n < 40);
        checks++; if (n != 17) begin failures++; $display("FAIL tmo_latency got=%0d exp=17", n); end
        checks++; if (bus.rq_ready !== 3'b010) begin failures++; $display("FAIL tmo_rq_ready got=%0h exp=2", bus.rq_ready); end
        checks++; if (bus.rq_dout !== 32'hFFFF_FFFF) begin failures++; $display("FAIL tmo_rq_dout got=%0h exp=ffffffff", bus.rq_dout); end
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0h exp=1", err_timeout); end
        bus.rq_req = 3'b000;
        repeat (4) tick();
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky got=%0h exp=1", err_timeout); end
    endtask

    task automatic test_race();
        int n;
        apply_reset();
        bus.rq_addr[0] = 27'h200;
        bus.rq_rnw[0]  = 1'b1;
        bus.rq_req     = 3'b001;
        n = 0;
        do begin tick(); n++; end while (bus.ch_req !== 1'b1 && n < 10);
        checks++; if (bus.ch_req !== 1'b1) begin failures++; $display("FAIL race_ch_req got=%0h exp=1", bus.ch_req); end
        // Ready lands on the edge where the wait counter equals TIMEOUT.
        repeat (16) tick();
        checks++; if (bus.rq_ready !== 3'b000) begin failures++; $display("FAIL race_early_ready got=%0h exp=0", bus.rq_ready); end
        bus.ch_ready = 1'b1;
        bus.ch_dout  = 32'h0000_1234;
        tick();
        bus.ch_ready = 1'b0;
        checks++; if (bus.rq_ready !== 3'b001) begin failures++; $display("FAIL race_rq_ready got=%0h exp=1", bus.rq_ready); end
        checks++; if (bus.rq_dout !== 32'h0000_1234) begin failures++; $display("FAIL race_rq_dout got=%0h exp=1234", bus.rq_dout); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL race_err got=%0h exp=0", err_timeout); end
        bus.rq_req = 3'b000;
        tick();
    endtask

    task automatic test_reset_in_wait();
        int n;
        bus.rq_addr[2] = 27'h5A5;
        bus.rq_din[2]  = 32'h1111_2222;
        bus.rq_rnw[2]  = 1'b1;
        bus.rq_req     = 3'b100;
        n = 0;
        do begin tick(); n++; end while (bus.ch_req !== 1'b1 && n < 10);
        checks++; if (bus.ch_rnw !== 1'b1) begin failures++; $display("FAIL rstw_ch_rnw got=%0h exp=1", bus.ch_rnw); end
        repeat (2) tick();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++; if (bus.ch_addr !== 27'd0) begin failures++; $display("FAIL rstw_ch_addr_async got=%0h exp=0", bus.ch_addr); end
        checks++; if (bus.rq_dout !== 32'd0) begin failures++; $display("FAIL rstw_rq_dout_async got=%0h exp=0", bus.rq_dout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chreq_cnt = 0;
        ready_cnt = 0;
        repeat (3) tick();
        bus.ch_ready = 1'b1;
        bus.ch_dout  = 32'hBAD0_BAD0;
        tick();
        bus.ch_ready = 1'b0;
        repeat (3) tick();
        checks++; if (ready_cnt != 0) begin failures++; $display("FAIL rstw_stale_ready got=%0d exp=0", ready_cnt); end
        checks++; if (chreq_cnt != 0) begin failures++; $display("FAIL rstw_ch_req got=%0d exp=0", chreq_cnt); end
        checks++; if (dut.state_r !== ST_IDLE) begin failures++; $display("FAIL rstw_state got=%0h exp=%0h", dut.state_r, ST_IDLE); end
        checks++; if (bus.rq_dout !== 32'd0) begin failures++; $display("FAIL rstw_rq_dout got=%0h exp=0", bus.rq_dout); end
        checks++; if ({bus.ch_addr, bus.ch_din, bus.ch_rnw} !== 60'd0) begin failures++; $display("FAIL rstw_ch_fields got=%0h exp=0", {bus.ch_addr, bus.ch_din, bus.ch_rnw}); end
        checks++; if ({err_timeout, grant_id} !== 3'd0) begin failures++; $display("FAIL rstw_err_grant got=%0h exp=0", {err_timeout, grant_id}); end
    endtask

    task automatic test_write();
        int n;
        chreq_cnt = 0;
        ready_cnt = 0;
        bus.rq_addr[2] = 27'h0AB_CDE;
        bus.rq_din[2]  = 32'hA5A5_A5A5;
        bus.rq_rnw[2]  = 1'b0;
        bus.rq_req     = 3'b100;
        n = 0;
        do begin tick(); n++; end while (bus.ch_req !== 1'b1 && n < 10);
        checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL wr_grant got=%0h exp=2", grant_id); end
        checks++; if (bus.ch_din !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_ch_din got=%0h exp=a5a5a5a5", bus.ch_din); end
        checks++; if (bus.ch_rnw !== 1'b0) begin failures++; $display("FAIL wr_ch_rnw got=%0h exp=0", bus.ch_rnw); end
        // Requester withdraws and changes its inputs after issue.
        bus.rq_req     = 3'b000;
        bus.rq_din[2]  = 32'h0000_0000;
        bus.rq_addr[2] = 27'h0;
        bus.rq_rnw[2]  = 1'b1;
        repeat (2) tick();
        checks++; if ({bus.ch_addr, bus.ch_din, bus.ch_rnw} !== {27'h0AB_CDE, 32'hA5A5_A5A5, 1'b0}) begin failures++; $display("FAIL wr_ch_stable got=%0h exp=%0h", {bus.ch_addr, bus.ch_din, bus.ch_rnw}, {27'h0AB_CDE, 32'hA5A5_A5A5, 1'b0}); end
        bus.ch_ready = 1'b1;
        bus.ch_dout  = 32'h0;
        tick();
        bus.ch_ready = 1'b0;
        checks++; if (bus.rq_ready !== 3'b100) begin failures++; $display("FAIL wr_rq_ready got=%0h exp=4", bus.rq_ready); end
        tick();
        tick();
        checks++; if (ready_cnt != 1) begin failures++; $display("FAIL wr_ready_count got=%0d exp=1", ready_cnt); end
        checks++; if (chreq_cnt != 1) begin failures++; $display("FAIL wr_ch_req_count got=%0d exp=1", chreq_cnt); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        chreq_cnt = 0;
        ready_cnt = 0;
        test_reset();
        test_single_read();
        test_fairness();
        test_timeout();
        test_race();
        test_reset_in_wait();
        test_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
